// File: rtl/selector41_pkg.sv
// rtl/selector41_pkg.sv - shared select codes and default width for selector_41
package selector41_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] SEL_C0 = 2'b00;
  localparam logic [1:0] SEL_C1 = 2'b01;
  localparam logic [1:0] SEL_C2 = 2'b10;
  localparam logic [1:0] SEL_C3 = 2'b11;

endpackage

// File: rtl/selector41_mux.sv
// rtl/selector41_mux.sv - combinational WIDTH-bit 4:1 mux
// An unknown select falls to the default arm, so simulation shows zeros rather than a stale word.
module selector41_mux
  import selector41_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] c0_i,
  input  logic [WIDTH-1:0] c1_i,
  input  logic [WIDTH-1:0] c2_i,
  input  logic [WIDTH-1:0] c3_i,
  output logic [WIDTH-1:0] z_o
);

  always_comb begin
    z_o = '0;
    case (sel_i)
      SEL_C0:  z_o = c0_i;
      SEL_C1:  z_o = c1_i;
      SEL_C2:  z_o = c2_i;
      SEL_C3:  z_o = c3_i;
      default: z_o = '0;
    endcase
  end

endmodule

// File: rtl/selector_41.sv
// rtl/selector_41.sv - registered 4-to-1 selector of WIDTH-bit words
// The output comes only from the register, so no input reaches oZ combinationally.
module selector_41
  import selector41_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  input  logic             iS1,
  input  logic             iS0,
  output logic [WIDTH-1:0] oZ
);

  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;

  selector41_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel_i({iS1, iS0}),
    .c0_i (iC0),
    .c1_i (iC1),
    .c2_i (iC2),
    .c3_i (iC3),
    .z_o  (z_d)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign oZ = z_q;

endmodule

// File: tb/tb_selector_41.sv
// tb/tb_selector_41.sv - scoreboard bench for selector_41
module tb_selector_41;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic [3:0] iC0  = 4'd0;
  logic [3:0] iC1  = 4'd0;
  logic [3:0] iC2  = 4'd0;
  logic [3:0] iC3  = 4'd0;
  logic       iS1  = 1'b0;
  logic       iS0  = 1'b0;
  logic [3:0] oZ;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  int         checks = 0;
  int         errors = 0;

  selector_41 #(.WIDTH(4)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iC0 (iC0),
    .iC1 (iC1),
    .iC2 (iC2),
    .iC3 (iC3),
    .iS1 (iS1),
    .iS0 (iS0),
    .oZ  (oZ)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load_ladder();
    iC0 = 4'b0001;
    iC1 = 4'b0011;
    iC2 = 4'b0111;
    iC3 = 4'b1111;
  endtask

  task automatic test_reset();
    load_ladder();
    iS1 = 1'b0;
    iS0 = 1'b0;
    #1 iRst = 1'b1;
    #1;
    checks++;
    if (oZ !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: oZ=%b expected=%b", oZ, 4'b0000);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (oZ !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: oZ=%b expected=%b", i, oZ, 4'b0000);
      end
    end
    iRst = 1'b0;
    exp_q.push_back(4'b0001);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (oZ !== exp_v) begin
      errors++;
      $display("FAIL reset_release: oZ=%b expected=%b", oZ, exp_v);
    end
  endtask

  task automatic test_select_sweep();
    logic [3:0] ladder[4];
    ladder[0] = 4'b0001;
    ladder[1] = 4'b0011;
    ladder[2] = 4'b0111;
    ladder[3] = 4'b1111;
    load_ladder();
    for (int s = 0; s < 4; s++) begin
      {iS1, iS0} = 2'(s);
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back(ladder[s]);
        tick();
        exp_v = exp_q.pop_front();
        checks++;
        if (oZ !== exp_v) begin
          errors++;
          $display("FAIL sweep sel=%0d cyc=%0d: oZ=%b expected=%b", s, c, oZ, exp_v);
        end
      end
    end
  endtask

  task automatic test_isolation();
    load_ladder();
    {iS1, iS0} = 2'b10;
    for (int i = 0; i < 8; i++) begin
      iC0 = 4'($urandom_range(0, 15));
      iC1 = 4'($urandom_range(0, 15));
      iC3 = 4'($urandom_range(0, 15));
      exp_q.push_back(4'b0111);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (oZ !== exp_v) begin
        errors++;
        $display("FAIL isolation[%0d]: oZ=%b expected=%b", i, oZ, exp_v);
      end
    end
  endtask

  task automatic test_data_tracking();
    logic [3:0] seq[4];
    seq[0] = 4'b0000;
    seq[1] = 4'b1010;
    seq[2] = 4'b0101;
    seq[3] = 4'b1111;
    load_ladder();
    {iS1, iS0} = 2'b11;
    for (int i = 0; i < 4; i++) begin
      iC3 = seq[i];
      exp_q.push_back(seq[i]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (oZ !== exp_v) begin
        errors++;
        $display("FAIL tracking[%0d]: oZ=%b expected=%b", i, oZ, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    load_ladder();
    {iS1, iS0} = 2'b01;
    exp_q.push_back(4'b0011);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (oZ !== exp_v) begin
      errors++;
      $display("FAIL midreset_pre: oZ=%b expected=%b", oZ, exp_v);
    end
    #1 iRst = 1'b1;
    #1;
    checks++;
    if (oZ !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear: oZ=%b expected=%b", oZ, 4'b0000);
    end
    #1 iRst = 1'b0;
    exp_q.push_back(4'b0011);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (oZ !== exp_v) begin
      errors++;
      $display("FAIL midreset_release: oZ=%b expected=%b", oZ, exp_v);
    end
  endtask

  task automatic test_x_select();
    iC0 = 4'b0000;
    iC1 = 4'b0000;
    iC2 = 4'b0111;
    iC3 = 4'b1111;
    {iS1, iS0} = 2'b11;
    tick();
    iS1 = 1'b0;
    iS0 = 1'bx;
    exp_q.push_back(4'b0000);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (oZ !== exp_v) begin
      errors++;
      $display("FAIL x_select: oZ=%b expected=%b", oZ, exp_v);
    end
    iS0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] words[4];
    int         sel;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 4; k++) words[k] = 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      iC0 = words[0];
      iC1 = words[1];
      iC2 = words[2];
      iC3 = words[3];
      {iS1, iS0} = 2'(sel);
      exp_q.push_back(words[sel]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (oZ !== exp_v) begin
        errors++;
        $display("FAIL back_to_back[%0d] sel=%0d: oZ=%b expected=%b", i, sel, oZ, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_isolation();
    test_data_tracking();
    test_async_reset();
    test_x_select();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
